gnr_node_sos_multi: RTL and testbench
=====================================

// Module: gnr_node_sos_multi
// PURPOSE
//  Parametrised per-node state holder for the GRN engine: NCOPY state copies of WIDTH bits.
//  Copy 0 updates once every DIV+1 starts; copies 1..NCOPY-1 update on every start.
//  Tracks update-to-update stability of copy 0 and flags a steady state (attractor candidate).
//  Sits between the node's update-rule (grb) logic and the network state bus (sos).
// PARAMETERS
//  WIDTH      1   bits per state value
//  NCOPY      2   number of state copies (>=1)
//  DIV_W      4   width of copy-0 divider input
//  CNT_W      8   width of the stability counter
//  STEADY_TH  4   consecutive unchanged copy-0 updates required to raise steady (1..2^CNT_W-1)
// PORTS
//  clk         in   1            clock, all logic on rising edge
//  rst         in   1            synchronous active-high reset
//  reset_nos   in   1            network re-init: load init_state into all copies
//  init_state  in   WIDTH        value loaded on reset_nos
//  div         in   DIV_W        copy-0 divider: update on 1 of every div+1 starts
//  start       in   NCOPY        start[i]: update request for copy i (1-cycle pulse)
//  grb         in   NCOPY*WIDTH  next-state candidate, copy i at [i*WIDTH +: WIDTH]
//  s           out  NCOPY*WIDTH  registered state copies
//  sos         out  NCOPY*WIDTH  state bus to network, equals s combinationally
//  changed     out  NCOPY        changed[i]=1 for one cycle after copy i updated to a different value
//  stable_cnt  out  CNT_W        consecutive unchanged copy-0 updates, saturating
//  steady      out  1            stable_cnt >= STEADY_TH (combinational from stable_cnt)
// BEHAVIOUR
//  Priority per edge: rst > reset_nos > start.
//  rst: s=0, changed=0, stable_cnt=0, phase=div (first div starts to copy 0 are skipped).
//  reset_nos: every copy <= init_state, phase=0, stable_cnt=0, changed=0.
//  Copy 0 divider (phase, DIV_W bits), evaluated only when start[0]=1:
//   - phase==0: s0 <= grb0, phase <= div (div sampled at this edge).
//   - phase!=0: s0 holds, phase <= phase-1.
//   - div=0 -> every start updates; div=1 -> update, skip, update, ...
//   - div changed mid-run takes effect at next reload; in-flight count not altered.
//  Copies i>=1: start[i]=1 -> s_i <= grb_i; no divider.
//  Latency: new value visible on s/sos the cycle after the accepting start edge.
//  changed[i]: registered, set on an accepting update where grb_i != s_i, else 0.
//   Skipped starts, idle cycles, reset_nos and rst all drive 0.
//  stable_cnt: on accepted copy-0 update only.
//   - grb0 == s0 -> increment, saturate at 2^CNT_W-1.
//   - grb0 != s0 -> clear to 0.
//   - Unchanged on skipped starts and on copies i>=1.
//  steady falls the cycle after a changing copy-0 update, rst or reset_nos.
//  start[i] asserted on consecutive cycles: each cycle is a separate request.
//  start held with reset_nos: start ignored, phase still loads 0.
//  rst mid-operation: full clear as above, no residual pulses.
// TESTING
//  1 rst, div=1, start[0] x4 with grb0=1 -> s0 updates on starts 2 and 4 only; changed[0] pulses once.
//  2 reset_nos, init_state=1, div=2, start[0] x6 -> updates on starts 1 and 4; s1 follows every start[1].
//  3 div=0, grb0 held = s0 for 5 updates, STEADY_TH=4 -> stable_cnt 1..5; steady high after 4th.
//  4 steady high, then grb0 flips on an update -> stable_cnt=0, steady=0, changed[0]=1 for 1 cycle.
//  5 CNT_W=2, 6 unchanged updates -> stable_cnt saturates at 3, no wrap.
//  6 rst and reset_nos high together mid-run -> s=0, phase=div, all outputs 0; then reset_nos alone -> all copies=init_state.

Source files
------------

// File: rtl/gnr_node_sos_multi.sv
// gnr_node_sos_multi: per-node state holder for the GRN engine.
// Holds NCOPY state copies. Copy 0 is clock-divided on its start strobe.
// The block tracks how many consecutive copy-0 updates left the value
// unchanged and raises steady once that run reaches STEADY_TH.
module gnr_node_sos_multi #(
  parameter int WIDTH     = 1,
  parameter int NCOPY     = 2,
  parameter int DIV_W     = 4,
  parameter int CNT_W     = 8,
  parameter int STEADY_TH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_nos,
  input  logic [WIDTH-1:0]       init_state,
  input  logic [DIV_W-1:0]       div,
  input  logic [NCOPY-1:0]       start,
  input  logic [NCOPY*WIDTH-1:0] grb,
  output logic [NCOPY*WIDTH-1:0] s,
  output logic [NCOPY*WIDTH-1:0] sos,
  output logic [NCOPY-1:0]       changed,
  output logic [CNT_W-1:0]       stable_cnt,
  output logic                   steady
);

  localparam logic [CNT_W-1:0] STEADY_TH_C = CNT_W'(STEADY_TH);

  logic [NCOPY*WIDTH-1:0] s_q, s_d;
  logic [NCOPY-1:0]       changed_q, changed_d;
  logic [DIV_W-1:0]       phase_q, phase_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Per-copy accept strobe and "candidate differs from held value" flag.
  logic [NCOPY-1:0] accept;
  logic [NCOPY-1:0] diff;

  genvar gi;
  generate
    for (gi = 0; gi < NCOPY; gi++) begin : g_copy
      if (gi == 0) begin : g_div
        // Copy 0 only accepts when the divider phase has run down to zero.
        assign accept[gi] = start[gi] && (phase_q == '0);
      end else begin : g_free
        assign accept[gi] = start[gi];
      end
      assign diff[gi] = (grb[gi*WIDTH +: WIDTH] != s_q[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  // Next-state: re-init has priority over start; changed pulses only on accepted, differing updates.
  always_comb begin
    s_d       = s_q;
    changed_d = '0;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    if (reset_nos) begin
      for (int i = 0; i < NCOPY; i++) begin
        s_d[i*WIDTH +: WIDTH] = init_state;
      end
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      for (int i = 0; i < NCOPY; i++) begin
        if (accept[i]) begin
          s_d[i*WIDTH +: WIDTH] = grb[i*WIDTH +: WIDTH];
        end
      end
      changed_d = accept & diff;
      // Divider reloads from the current div only at the accepting edge,
      // so a div change mid-count does not disturb the count in flight.
      if (start[0]) begin
        if (phase_q == '0) begin
          phase_d = div;
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      // Stability run length counts accepted copy-0 updates only, saturating.
      if (accept[0]) begin
        if (diff[0]) begin
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State register; after rst the first div starts to copy 0 are skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      changed_q <= '0;
      phase_q   <= div;
      cnt_q     <= '0;
    end else begin
      s_q       <= s_d;
      changed_q <= changed_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s          = s_q;
  assign sos        = s_q;
  assign changed    = changed_q;
  assign stable_cnt = cnt_q;
  assign steady     = (cnt_q >= STEADY_TH_C);

endmodule

// File: tb/tb_gnr_node_sos_multi.sv
// Testbench for gnr_node_sos_multi: two instances (8-bit and 2-bit stability
// counters) share stimulus and are compared against a behavioural model.
module tb_gnr_node_sos_multi;

  localparam int W = 2;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           reset_nos = 1'b0;
  logic [W-1:0]   init_state = '0;
  logic [3:0]     div = '0;
  logic [N-1:0]   start = '0;
  logic [N*W-1:0] grb = '0;

  logic [N*W-1:0] s_a, sos_a, s_b, sos_b;
  logic [N-1:0]   changed_a, changed_b;
  logic [7:0]     cnt_a;
  logic [1:0]     cnt_b;
  logic           steady_a, steady_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gnr_node_sos_multi #(.WIDTH(W), .NCOPY(N), .DIV_W(4), .CNT_W(8), .STEADY_TH(4)) dut_a (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state), .div(div),
    .start(start), .grb(grb), .s(s_a), .sos(sos_a), .changed(changed_a),
    .stable_cnt(cnt_a), .steady(steady_a));

  gnr_node_sos_multi #(.WIDTH(W), .NCOPY(N), .DIV_W(4), .CNT_W(2), .STEADY_TH(3)) dut_b (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state), .div(div),
    .start(start), .grb(grb), .s(s_b), .sos(sos_b), .changed(changed_b),
    .stable_cnt(cnt_b), .steady(steady_b));

  logic [35:0] obs;
  assign obs = {s_a, sos_a, changed_a, cnt_a, steady_a, cnt_b, steady_b, s_b, changed_b};

  // Behavioural model: each copy value, divider skip count, run lengths.
  logic [W-1:0] m_s [N];
  logic [N-1:0] m_chg;
  int           m_skip;
  int           m_cnt;
  int           m_cnt2;

  task automatic model_step();
    logic [W-1:0] g;
    bit take;
    if (rst) begin
      for (int i = 0; i < N; i++) m_s[i] = '0;
      m_chg = '0; m_cnt = 0; m_cnt2 = 0; m_skip = int'(div);
    end else if (reset_nos) begin
      for (int i = 0; i < N; i++) m_s[i] = init_state;
      m_chg = '0; m_cnt = 0; m_cnt2 = 0; m_skip = 0;
    end else begin
      m_chg = '0;
      for (int i = 0; i < N; i++) begin
        if (start[i]) begin
          take = 1'b1;
          if (i == 0) begin
            if (m_skip == 0) m_skip = int'(div);
            else begin m_skip = m_skip - 1; take = 1'b0; end
          end
          if (take) begin
            g = grb[i*W +: W];
            m_chg[i] = (g != m_s[i]);
            if (i == 0) begin
              if (g == m_s[0]) begin
                m_cnt  = (m_cnt  >= 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 >= 3)   ? 3   : m_cnt2 + 1;
              end else begin
                m_cnt = 0; m_cnt2 = 0;
              end
            end
            m_s[i] = g;
          end
        end
      end
    end
  endtask

  function automatic logic [35:0] exp_vec();
    logic [N*W-1:0] es;
    for (int i = 0; i < N; i++) es[i*W +: W] = m_s[i];
    return {es, es, m_chg, 8'(m_cnt), (m_cnt >= 4), 2'(m_cnt2), (m_cnt2 >= 3), es, m_chg};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    div = 4'd1; rst = 1'b1; reset_nos = 1'b0; start = '0;
    tick();
    tests++; if (obs !== exp_vec()) begin $display("FAIL reset_vec: got %h want %h", obs, exp_vec()); fails++; end
    tests++; if ({s_a, changed_a, cnt_a, steady_a} !== '0) begin
      $display("FAIL reset_zero: got s=%h chg=%b cnt=%0d steady=%b want all 0", s_a, changed_a, cnt_a, steady_a); fails++; end
    rst = 1'b0;
    tick();
    tests++; if (obs !== exp_vec()) begin $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); fails++; end
  endtask

  // After rst with div=1: start 1 skipped, 2 taken, 3 skipped, 4 taken.
  task automatic test_divider();
    logic [W-1:0] want_s0 [4];
    int pulses;
    want_s0 = '{2'd0, 2'd1, 2'd1, 2'd1};
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      start = 3'b001; grb = 6'b000001;
      tick();
      pulses += int'(changed_a[0]);
      tests++; if (obs !== exp_vec()) begin $display("FAIL divider_vec[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
      tests++; if (s_a[1:0] !== want_s0[k]) begin $display("FAIL divider_s0[%0d]: got %0d want %0d", k, s_a[1:0], want_s0[k]); fails++; end
    end
    start = '0;
    tick();
    tests++; if (pulses != 1 || changed_a !== '0) begin
      $display("FAIL divider_pulses: got %0d pulses chg=%b want 1 pulse chg=000", pulses, changed_a); fails++; end
  endtask

  // reset_nos with div=2: copy 0 accepts on starts 1 and 4, copy 1 on every start.
  task automatic test_reinit();
    logic [W-1:0] want_s0 [6];
    want_s0 = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    init_state = 2'd1; div = 4'd2; reset_nos = 1'b1; start = 3'b111;
    tick();
    tests++; if (s_a !== 6'b010101 || obs !== exp_vec()) begin
      $display("FAIL reinit_load: got %h want s=15 vec %h", obs, exp_vec()); fails++; end
    reset_nos = 1'b0;
    for (int k = 0; k < 6; k++) begin
      start = 3'b011;
      grb = {2'($urandom), 2'($urandom), 2'(k + 2)};
      tick();
      tests++; if (obs !== exp_vec()) begin $display("FAIL reinit_vec[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
      tests++; if (s_a[1:0] !== want_s0[k] || s_a[3:2] !== grb[3:2]) begin
        $display("FAIL reinit_seq[%0d]: got s0=%0d s1=%0d want s0=%0d s1=%0d", k, s_a[1:0], s_a[3:2], want_s0[k], grb[3:2]); fails++; end
    end
    start = '0;
  endtask

  // Unchanged copy-0 updates grow the run; a differing update clears it.
  task automatic test_steady();
    init_state = 2'd2; reset_nos = 1'b1; start = '0; div = 4'd0;
    tick();
    reset_nos = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      start = 3'b001; grb = {4'($urandom), 2'd2};
      tick();
      tests++; if (cnt_a !== 8'(k) || steady_a !== (k >= 4)) begin
        $display("FAIL steady_run[%0d]: got cnt=%0d steady=%b want cnt=%0d steady=%b", k, cnt_a, steady_a, k, (k >= 4)); fails++; end
      tests++; if (obs !== exp_vec()) begin $display("FAIL steady_vec[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
    end
    grb[1:0] = 2'd1;
    tick();
    tests++; if (cnt_a !== 8'd0 || steady_a !== 1'b0 || changed_a[0] !== 1'b1) begin
      $display("FAIL steady_break: got cnt=%0d steady=%b chg0=%b want 0 0 1", cnt_a, steady_a, changed_a[0]); fails++; end
    start = '0;
    tick();
    tests++; if (changed_a !== '0 || obs !== exp_vec()) begin
      $display("FAIL steady_pulse_end: got %h want %h", obs, exp_vec()); fails++; end
  endtask

  // 2-bit counter saturates at 3; 8-bit counter keeps counting.
  task automatic test_saturate();
    init_state = 2'd0; reset_nos = 1'b1; start = '0; div = 4'd0;
    tick();
    reset_nos = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      start = 3'b001; grb = 6'd0;
      tick();
      tests++; if (cnt_b !== 2'((k > 3) ? 3 : k) || cnt_a !== 8'(k) || steady_b !== (k >= 3)) begin
        $display("FAIL saturate[%0d]: got cnt2=%0d cnt8=%0d steady2=%b want %0d %0d %b",
                 k, cnt_b, cnt_a, steady_b, (k > 3) ? 3 : k, k, (k >= 3)); fails++; end
    end
    start = '0;
  endtask

  // rst beats reset_nos and start; then reset_nos alone reloads every copy.
  task automatic test_reset_priority();
    div = 4'd2;
    for (int k = 0; k < 3; k++) begin
      start = 3'b111; grb = 6'($urandom);
      tick();
      tests++; if (obs !== exp_vec()) begin $display("FAIL prio_pre[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
    end
    rst = 1'b1; reset_nos = 1'b1; start = 3'b111; grb = 6'b111111; init_state = 2'd3;
    tick();
    tests++; if ({s_a, changed_a, cnt_a, steady_a, s_b, cnt_b} !== '0) begin
      $display("FAIL prio_rst: got s=%h chg=%b cnt=%0d steady=%b want all 0", s_a, changed_a, cnt_a, steady_a); fails++; end
    rst = 1'b0; reset_nos = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start = 3'b001; grb = 6'b000011;
      tick();
      tests++; if (s_a[1:0] !== ((k == 2) ? 2'd3 : 2'd0) || obs !== exp_vec()) begin
        $display("FAIL prio_phase[%0d]: got s0=%0d want %0d", k, s_a[1:0], (k == 2) ? 3 : 0); fails++; end
    end
    start = '0; reset_nos = 1'b1;
    tick();
    tests++; if (s_a !== 6'b111111 || s_b !== 6'b111111 || cnt_a !== 8'd0) begin
      $display("FAIL prio_reinit: got s=%h cnt=%0d want s=3f cnt=0", s_a, cnt_a); fails++; end
    reset_nos = 1'b0;
  endtask

  // Consecutive starts are separate requests; start held with reset_nos is ignored.
  task automatic test_back_to_back();
    init_state = 2'd0; reset_nos = 1'b1; div = 4'd0;
    tick();
    reset_nos = 1'b0;
    for (int k = 0; k < 6; k++) begin
      start = 3'b111; grb = 6'($urandom);
      tick();
      tests++; if (obs !== exp_vec()) begin $display("FAIL b2b_vec[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
    end
    div = 4'd3; reset_nos = 1'b1; start = 3'b111; grb = 6'b101010;
    tick();
    tests++; if (s_a !== 6'd0 || changed_a !== '0 || obs !== exp_vec()) begin
      $display("FAIL b2b_hold_reinit: got %h want %h", obs, exp_vec()); fails++; end
    reset_nos = 1'b0; start = 3'b001; grb = 6'b000010;
    tick();
    tests++; if (s_a[1:0] !== 2'd2 || changed_a[0] !== 1'b1) begin
      $display("FAIL b2b_phase0: got s0=%0d chg0=%b want 2 1", s_a[1:0], changed_a[0]); fails++; end
    start = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(63) == 0);
      reset_nos = ($urandom_range(31) == 0);
      init_state = 2'($urandom);
      div   = 4'($urandom_range(3));
      start = 3'($urandom);
      grb   = 6'($urandom);
      if ($urandom_range(3) != 0) grb[1:0] = m_s[0];
      tick();
      tests++; if (obs !== exp_vec()) begin $display("FAIL random[%0d]: got %h want %h", k, obs, exp_vec()); fails++; end
    end
    rst = 1'b0; reset_nos = 1'b0; start = '0;
  endtask

  initial begin
    test_reset();
    test_divider();
    test_reinit();
    test_steady();
    test_saturate();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
